// File: rtl/pc_unit_ras.sv
// -----------------------------------------------------------------------------
// pc_unit_ras
//
// Program-counter unit for the MIPS fetch stage. Holds the fetch PC and picks
// the next PC by fixed priority:
//   exc > stall > branch > jump > ret (RAS hit) > pc + 4
// Every selected target has bits [1:0] forced to zero.
//
// Optional feature, enabled by defining the macro PC_RAS_EN:
//   a return-address stack (circular buffer, RAS_DEPTH x WIDTH). It predicts
//   `jr $ra` targets. Without the macro, call/ret are ignored and the RAS
//   flags are tied to empty / not full / no underflow.
//
// Parameters
//   WIDTH         PC width in bits (>= 8)
//   RESET_VECTOR  PC value held while rst is low (bits [1:0] zero)
//   EXC_VECTOR    exception handler address, truncated to WIDTH
//   RAS_DEPTH     RAS entries, power of two, 2..16
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   stall          hold PC and RAS (ignored when exc = 1)
//   exc            redirect to EXC_VECTOR, flush RAS
//   branch         redirect to pc_branch
//   pc_branch      branch target
//   jump           redirect to pc_jump
//   pc_jump        jump target
//   call           current fetch is jal/jalr: push pc + 4
//   ret            current fetch is jr $ra: pop and redirect to top entry
//   pc             registered fetch PC
//   pc_next        combinational next PC
//   ras_empty      RAS holds no valid entry
//   ras_full       RAS count equals RAS_DEPTH
//   ras_underflow  registered one-cycle pulse: ret accepted with RAS empty
// -----------------------------------------------------------------------------
module pc_unit_ras #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [31:0]      EXC_VECTOR   = 32'h0000_0180,
   parameter int               RAS_DEPTH    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             exc,
   input  logic             branch,
   input  logic [WIDTH-1:0] pc_branch,
   input  logic             jump,
   input  logic [WIDTH-1:0] pc_jump,
   input  logic             call,
   input  logic             ret,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_next,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_underflow
);

   localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
   localparam logic [WIDTH-1:0] EXC_TARGET = WIDTH'(EXC_VECTOR) & ALIGN_MASK;

   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] pc_d;
   logic [WIDTH-1:0] pc_seq;
   logic             ret_hit;
   logic [WIDTH-1:0] ras_top;

   // pc_q[1:0] is always zero, so this wraps cleanly modulo 2^WIDTH.
   assign pc_seq = pc_q + WIDTH'(4);

`ifdef PC_RAS_EN
   localparam int               PTR_W   = $clog2(RAS_DEPTH);
   localparam int               CNT_W   = $clog2(RAS_DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

   logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
   logic [WIDTH-1:0] ras_mem_d [RAS_DEPTH];
   logic [PTR_W-1:0] top_q;
   logic [PTR_W-1:0] top_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             underflow_q;
   logic             underflow_d;
   logic             accept;
   logic             do_pop;
   logic             do_push;
   logic [PTR_W-1:0] base_ptr;
   logic [PTR_W-1:0] wr_ptr;

   assign ras_empty     = (cnt_q == '0);
   assign ras_full      = (cnt_q == CNT_MAX);
   assign ras_underflow = underflow_q;

   assign accept  = ~exc & ~stall;
   assign do_pop  = accept & ret & ~ras_empty;
   assign do_push = accept & call;

   // Pop happens before push: a simultaneous call/ret rewrites the current
   // top slot. When full, top + 1 is the oldest entry, so a push naturally
   // overwrites it.
   assign base_ptr = do_pop ? (top_q - PTR_W'(1)) : top_q;
   assign wr_ptr   = base_ptr + PTR_W'(1);

   // The prediction uses the pre-pop top entry.
   assign ret_hit = ret & ~ras_empty;
   assign ras_top = ras_mem_q[top_q];

   always_comb begin
      ras_mem_d   = ras_mem_q;
      top_d       = top_q;
      cnt_d       = cnt_q;
      underflow_d = accept & ret & ras_empty;
      if (exc) begin
         cnt_d = '0;
      end else if (do_push) begin
         ras_mem_d[wr_ptr] = pc_seq;
         top_d             = wr_ptr;
         if (!do_pop && !ras_full) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (do_pop) begin
         top_d = base_ptr;
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         top_q       <= '0;
         cnt_q       <= '0;
         underflow_q <= 1'b0;
      end else begin
         top_q       <= top_d;
         cnt_q       <= cnt_d;
         underflow_q <= underflow_d;
      end
   end

   // Entry storage is validated by cnt_q, so it needs no reset.
   always_ff @(posedge clk) begin
      ras_mem_q <= ras_mem_d;
   end
`else
   logic unused_ras_in;

   assign unused_ras_in = call ^ ret;
   assign ret_hit       = 1'b0;
   assign ras_top       = '0;
   assign ras_empty     = 1'b1;
   assign ras_full      = 1'b0;
   assign ras_underflow = 1'b0;
`endif

   always_comb begin
      pc_d = pc_seq;
      if (exc) begin
         pc_d = EXC_TARGET;
      end else if (stall) begin
         pc_d = pc_q;
      end else if (branch) begin
         pc_d = pc_branch & ALIGN_MASK;
      end else if (jump) begin
         pc_d = pc_jump & ALIGN_MASK;
      end else if (ret_hit) begin
         pc_d = ras_top & ALIGN_MASK;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q <= RESET_VECTOR;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc      = pc_q;
   assign pc_next = pc_d;

endmodule

// File: tb/tb_pc_unit_ras.sv
// -----------------------------------------------------------------------------
// tb_pc_unit_ras
//
// Scoreboard bench for pc_unit_ras. The driver applies one directed vector per
// cycle, just after the rising edge, and pushes the hand-computed expectation
// (pc, pc_next, {ras_empty, ras_full, ras_underflow}) into a queue. A monitor
// on the falling edge pops and compares. Two instances are used: a 32-bit one
// with RESET_VECTOR 0x0040_0000 and RAS_DEPTH 4, and an 8-bit one for the
// narrow wrap case. Expected RAS behaviour follows whether PC_RAS_EN is set.
// -----------------------------------------------------------------------------
module tb_pc_unit_ras;

`ifdef PC_RAS_EN
   localparam bit RAS_ON = 1'b1;
`else
   localparam bit RAS_ON = 1'b0;
`endif

   localparam logic [5:0] NONE = 6'b000000;
   localparam logic [5:0] EXC  = 6'b100000;
   localparam logic [5:0] STL  = 6'b010000;
   localparam logic [5:0] BR   = 6'b001000;
   localparam logic [5:0] JMP  = 6'b000100;
   localparam logic [5:0] CAL  = 6'b000010;
   localparam logic [5:0] RET  = 6'b000001;

   typedef struct {
      int          which;
      string       name;
      bit          chk_pc;
      logic [31:0] pc;
      logic [31:0] pc_next;
      logic [2:0]  flags;
   } exp_t;

   exp_t sb[$];
   int   n_run  = 0;
   int   n_fail = 0;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        a_stall = 1'b0, a_exc = 1'b0, a_branch = 1'b0, a_jump = 1'b0;
   logic        a_call = 1'b0, a_ret = 1'b0;
   logic [31:0] a_pc_branch = '0, a_pc_jump = '0;
   logic [31:0] a_pc, a_pc_next;
   logic        a_empty, a_full, a_uf;

   logic        b_jump = 1'b0;
   logic [7:0]  b_pc_jump = '0;
   logic [7:0]  b_pc, b_pc_next;
   logic        b_empty, b_full, b_uf;

   always #5 clk = ~clk;

   pc_unit_ras #(
      .WIDTH(32), .RESET_VECTOR(32'h0040_0000),
      .EXC_VECTOR(32'h0000_0180), .RAS_DEPTH(4)
   ) dut_a (
      .clk(clk), .rst(rst), .stall(a_stall), .exc(a_exc),
      .branch(a_branch), .pc_branch(a_pc_branch),
      .jump(a_jump), .pc_jump(a_pc_jump),
      .call(a_call), .ret(a_ret),
      .pc(a_pc), .pc_next(a_pc_next),
      .ras_empty(a_empty), .ras_full(a_full), .ras_underflow(a_uf)
   );

   pc_unit_ras #(
      .WIDTH(8), .RESET_VECTOR(8'h00),
      .EXC_VECTOR(32'h0000_0180), .RAS_DEPTH(4)
   ) dut_b (
      .clk(clk), .rst(rst), .stall(1'b0), .exc(1'b0),
      .branch(1'b0), .pc_branch(8'h00),
      .jump(b_jump), .pc_jump(b_pc_jump),
      .call(1'b0), .ret(1'b0),
      .pc(b_pc), .pc_next(b_pc_next),
      .ras_empty(b_empty), .ras_full(b_full), .ras_underflow(b_uf)
   );

   // Expected flags {empty, full, underflow}; without the RAS they are fixed.
   function automatic logic [2:0] fl(input bit e, input bit f, input bit u);
      return RAS_ON ? {e, f, u} : 3'b100;
   endfunction

   // Pick the expected value for the RAS build or the plain build.
   function automatic logic [31:0] rs(input logic [31:0] with_ras,
                                      input logic [31:0] without_ras);
      return RAS_ON ? with_ras : without_ras;
   endfunction

   task automatic check(input string nm, input string fld,
                        input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, exp);
      end
   endtask

   task automatic step(input string nm, input logic [5:0] ctl,
                       input logic [31:0] pb, input logic [31:0] pj,
                       input logic [31:0] epc, input logic [31:0] enext,
                       input logic [2:0] efl);
      exp_t e;
      @(posedge clk);
      #1;
      {a_exc, a_stall, a_branch, a_jump, a_call, a_ret} = ctl;
      a_pc_branch = pb;
      a_pc_jump   = pj;
      e.which   = 0;
      e.name    = nm;
      e.chk_pc  = 1'b1;
      e.pc      = epc;
      e.pc_next = enext;
      e.flags   = efl;
      sb.push_back(e);
   endtask

   task automatic stepb(input string nm, input bit cpc, input logic [7:0] epc,
                        input logic [7:0] enext, input logic jmp,
                        input logic [7:0] pj);
      exp_t e;
      @(posedge clk);
      #1;
      b_jump    = jmp;
      b_pc_jump = pj;
      e.which   = 1;
      e.name    = nm;
      e.chk_pc  = cpc;
      e.pc      = {24'h0, epc};
      e.pc_next = {24'h0, enext};
      e.flags   = 3'b100;
      sb.push_back(e);
   endtask

   // Monitor: compare everything queued since the last falling edge.
   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] act_pc, act_next;
      logic [2:0]  act_fl;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.which == 0) begin
            act_pc   = a_pc;
            act_next = a_pc_next;
            act_fl   = {a_empty, a_full, a_uf};
         end else begin
            act_pc   = {24'h0, b_pc};
            act_next = {24'h0, b_pc_next};
            act_fl   = {b_empty, b_full, b_uf};
         end
         if (e.chk_pc) check(e.name, "pc", act_pc, e.pc);
         check(e.name, "pc_next", act_next, e.pc_next);
         check(e.name, "flags", {29'h0, act_fl}, {29'h0, e.flags});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset held: reset vector visible, RAS empty.
      step("rst_hold", NONE, 0, 0, 32'h0040_0000, 32'h0040_0004, 3'b100);
      @(negedge clk);
      #1 rst = 1'b1;

      step("seq1", NONE, 0, 0, 32'h0040_0004, 32'h0040_0008, 3'b100);
      step("seq2", NONE, 0, 0, 32'h0040_0008, 32'h0040_000C, 3'b100);
      step("jmp10", JMP, 0, 32'h10, 32'h0040_000C, 32'h10, 3'b100);
      step("stall_jmp", STL | JMP, 0, 32'h500, 32'h10, 32'h10, 3'b100);
      step("stall_br", STL | BR, 32'h200, 0, 32'h10, 32'h10, 3'b100);
      step("br_over_jmp", BR | JMP, 32'h103, 32'h300, 32'h10, 32'h100, 3'b100);
      step("jmp20", JMP, 0, 32'h20, 32'h100, 32'h20, 3'b100);
      step("call20", CAL, 0, 0, 32'h20, 32'h24, 3'b100);
      step("jmp80", JMP, 0, 32'h80, 32'h24, 32'h80, fl(0, 0, 0));
      step("ret80", RET, 0, 0, 32'h80, rs(32'h24, 32'h84), fl(0, 0, 0));
      step("jmp0", JMP, 0, 32'h0, rs(32'h24, 32'h84), 32'h0, 3'b100);

      // Five calls into a four-deep stack, then five returns.
      step("call0", CAL | JMP, 0, 32'h10, 32'h0, 32'h10, 3'b100);
      step("call10", CAL | JMP, 0, 32'h20, 32'h10, 32'h20, fl(0, 0, 0));
      step("call20b", CAL | JMP, 0, 32'h30, 32'h20, 32'h30, fl(0, 0, 0));
      step("call30", CAL | JMP, 0, 32'h40, 32'h30, 32'h40, fl(0, 0, 0));
      step("call40", CAL | JMP, 0, 32'h1000, 32'h40, 32'h1000, fl(0, 1, 0));
      step("ret1", RET, 0, 0, 32'h1000, rs(32'h44, 32'h1004), fl(0, 1, 0));
      step("ret2", RET, 0, 0, rs(32'h44, 32'h1004), rs(32'h34, 32'h1008), fl(0, 0, 0));
      step("ret3", RET, 0, 0, rs(32'h34, 32'h1008), rs(32'h24, 32'h100C), fl(0, 0, 0));
      step("ret4", RET, 0, 0, rs(32'h24, 32'h100C), rs(32'h14, 32'h1010), fl(0, 0, 0));
      step("ret5_empty", RET, 0, 0, rs(32'h14, 32'h1010), rs(32'h18, 32'h1014), 3'b100);
      step("uf_pulse", NONE, 0, 0, rs(32'h18, 32'h1014), rs(32'h1C, 32'h1018), fl(1, 0, 1));
      step("jmp200", JMP, 0, 32'h200, rs(32'h1C, 32'h1018), 32'h200, 3'b100);

      // Exception beats stall/branch, blocks the push and flushes the RAS.
      step("call200", CAL | JMP, 0, 32'h300, 32'h200, 32'h300, 3'b100);
      step("call300", CAL, 0, 0, 32'h300, 32'h304, fl(0, 0, 0));
      step("exc", EXC | STL | BR | CAL, 32'h500, 0, 32'h304, 32'h180, fl(0, 0, 0));
      step("post_exc", NONE, 0, 0, 32'h180, 32'h184, 3'b100);
      step("ret_flushed", RET, 0, 0, 32'h184, 32'h188, 3'b100);
      step("call188", CAL, 0, 0, 32'h188, 32'h18C, fl(1, 0, 1));

      // Simultaneous call and ret replaces the top entry.
      step("jmp400", JMP, 0, 32'h400, 32'h18C, 32'h400, fl(0, 0, 0));
      step("call_ret", CAL | RET, 0, 0, 32'h400, rs(32'h18C, 32'h404), fl(0, 0, 0));
      step("jmp600", JMP, 0, 32'h600, rs(32'h18C, 32'h404), 32'h600, fl(0, 0, 0));
      step("ret600", RET, 0, 0, 32'h600, rs(32'h404, 32'h604), fl(0, 0, 0));

      // A stalled call must not push.
      step("stall_call", STL | CAL, 0, 0, rs(32'h404, 32'h604), rs(32'h404, 32'h604), 3'b100);
      step("after_stall", NONE, 0, 0, rs(32'h404, 32'h604), rs(32'h408, 32'h608), 3'b100);

      // 32-bit wrap.
      step("jmp_top", JMP, 0, 32'hFFFF_FFFF, rs(32'h408, 32'h608), 32'hFFFF_FFFC, 3'b100);
      step("wrap32", NONE, 0, 0, 32'hFFFF_FFFC, 32'h0, 3'b100);
      step("after_wrap", NONE, 0, 0, 32'h0, 32'h4, 3'b100);

      // 8-bit instance: 0xFC wraps to 0x00.
      stepb("b_jmp", 1'b0, 8'h00, 8'hFC, 1'b1, 8'hFF);
      stepb("b_wrap", 1'b1, 8'hFC, 8'h00, 1'b0, 8'h00);
      stepb("b_after", 1'b1, 8'h00, 8'h04, 1'b0, 8'h00);

      repeat (3) @(negedge clk);
      #1;
      n_run++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d records left, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
